// File: rtl/gcd_host_if.sv
// Handshake bundle between the GCD host sequencer (master) and its environment:
// request stream, result stream and the engine's start/data/done port.
interface gcd_host_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_timeout;
  logic       gcd_start;
  logic [7:0] gcd_data_in;
  logic [7:0] gcd_data_out;
  logic       gcd_done;

  modport master (
    input  req_valid, req_a, req_b, res_ready, gcd_data_out, gcd_done,
    output req_ready, res_valid, res_data, res_timeout, gcd_start, gcd_data_in
  );

  modport slave (
    output req_valid, req_a, req_b, res_ready, gcd_data_out, gcd_done,
    input  req_ready, res_valid, res_data, res_timeout, gcd_start, gcd_data_in
  );
endinterface

// File: rtl/gcd_host.sv
// Host sequencer for the 8-bit GCD engine: loads A then B, waits for done under a watchdog.
// States: IDLE accept pair | LOAD_A start pulse + A | LOAD_B present B | WAIT poll done | RESP hold result
module gcd_host #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic      clk,
  input  logic      reset,
  gcd_host_if.master bus
);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, WAIT, RESP} state_t;

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  b_q;
  logic [15:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      b_q             <= 8'd0;
      wait_cnt        <= 16'd0;
      bus.req_ready   <= 1'b1;
      bus.res_valid   <= 1'b0;
      bus.res_data    <= 8'd0;
      bus.res_timeout <= 1'b0;
      bus.gcd_start   <= 1'b0;
      bus.gcd_data_in <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            b_q           <= bus.req_b;
            // Zero operands never reach the engine: gcd(x,0) = x, gcd(0,0) = 0.
            if (bus.req_a == 8'd0 || bus.req_b == 8'd0) begin
              bus.res_valid   <= 1'b1;
              bus.res_data    <= bus.req_a | bus.req_b;
              bus.res_timeout <= 1'b0;
              state           <= RESP;
            end else begin
              bus.gcd_start   <= 1'b1;
              bus.gcd_data_in <= bus.req_a;
              state           <= LOAD_A;
            end
          end
        end
        LOAD_A: begin
          bus.gcd_start   <= 1'b0;
          bus.gcd_data_in <= b_q;
          state           <= LOAD_B;
        end
        LOAD_B: begin
          bus.gcd_data_in <= 8'd0;
          wait_cnt        <= 16'd0;
          state           <= WAIT;
        end
        WAIT: begin
          // done is only honoured here, so a level left over from the last run is ignored.
          if (bus.gcd_done) begin
            bus.res_valid   <= 1'b1;
            bus.res_data    <= bus.gcd_data_out;
            bus.res_timeout <= 1'b0;
            state           <= RESP;
          end else if (wait_cnt == LIMIT) begin
            bus.res_valid   <= 1'b1;
            bus.res_data    <= 8'd0;
            bus.res_timeout <= 1'b1;
            state           <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_host.sv
// Bench for gcd_host: two instances (default watchdog and TIMEOUT=8) share stimulus through a selector;
// results and timing are predicted from plain Euclid arithmetic and the documented cycle offsets.
module tb_gcd_host;
  logic       clk = 1'b0;
  logic       reset;
  logic       sel;
  logic       req_valid, res_ready, gcd_done;
  logic [7:0] req_a, req_b, gcd_data_out;
  logic [7:0] ra, rb;
  int         rk;
  int         vectors = 0;
  int         miscompares = 0;

  gcd_host_if if_d();
  gcd_host_if if_t();

  gcd_host dut_d (.clk(clk), .reset(reset), .bus(if_d.master));
  gcd_host #(.TIMEOUT(8)) dut_t (.clk(clk), .reset(reset), .bus(if_t.master));

  always #5 clk = ~clk;

  assign if_d.req_valid    = !sel && req_valid;
  assign if_t.req_valid    = sel && req_valid;
  assign if_d.req_a        = req_a;
  assign if_t.req_a        = req_a;
  assign if_d.req_b        = req_b;
  assign if_t.req_b        = req_b;
  assign if_d.res_ready    = res_ready;
  assign if_t.res_ready    = res_ready;
  assign if_d.gcd_done     = !sel && gcd_done;
  assign if_t.gcd_done     = sel && gcd_done;
  assign if_d.gcd_data_out = gcd_data_out;
  assign if_t.gcd_data_out = gcd_data_out;

  logic       o_req_ready, o_res_valid, o_res_timeout, o_gcd_start;
  logic [7:0] o_res_data, o_gcd_data_in;
  assign o_req_ready   = sel ? if_t.req_ready   : if_d.req_ready;
  assign o_res_valid   = sel ? if_t.res_valid   : if_d.res_valid;
  assign o_res_timeout = sel ? if_t.res_timeout : if_d.res_timeout;
  assign o_res_data    = sel ? if_t.res_data    : if_d.res_data;
  assign o_gcd_start   = sel ? if_t.gcd_start   : if_d.gcd_start;
  assign o_gcd_data_in = sel ? if_t.gcd_data_in : if_d.gcd_data_in;

  function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
    int x, y, t;
    x = int'(a);
    y = int'(b);
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return 8'(x);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Caller sits at a negedge with the host idle. k = WAIT cycle in which done is first seen (-1: never).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int k, input int hold);
    int         tmo, lat, exp_lat, starts;
    logic       zero, exp_to;
    logic [7:0] exp_data, sa, sb, held;
    tmo  = sel ? 8 : 255;
    zero = (a == 8'd0) || (b == 8'd0);
    if (zero) begin
      exp_lat = 1; exp_data = ref_gcd(a, b); exp_to = 1'b0;
    end else if (k >= 0 && k < tmo) begin
      exp_lat = 4 + k; exp_data = ref_gcd(a, b); exp_to = 1'b0;
    end else begin
      exp_lat = 3 + tmo; exp_data = 8'd0; exp_to = 1'b1;
    end
    chk("req_ready_idle", o_req_ready, 1);
    res_ready = (hold == 0);
    req_valid = 1'b1; req_a = a; req_b = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_a = 8'($urandom); req_b = 8'($urandom);
    chk("accept_next_edge", o_req_ready, 0);
    lat = -1; starts = 0; sa = 8'd0; sb = 8'd0;
    for (int j = 1; j <= 300; j++) begin
      if (j > 1) @(negedge clk);
      if (o_gcd_start === 1'b1) starts++;
      if (!zero && j == 1) begin
        chk("start_pulse", o_gcd_start, 1);
        chk("operand_a", o_gcd_data_in, a);
        sa = o_gcd_data_in;
      end
      if (!zero && j == 2) begin
        chk("start_low", o_gcd_start, 0);
        chk("operand_b", o_gcd_data_in, b);
        sb = o_gcd_data_in;
      end
      if (!zero && j == 3) chk("wait_bus_zero", o_gcd_data_in, 0);
      if (o_res_valid === 1'b1) begin
        lat = j;
        break;
      end
      if (!zero && j >= 3) begin
        gcd_done = (k >= 0) && (j >= 3 + k);
        if (gcd_done) gcd_data_out = ref_gcd(sa, sb);
      end
    end
    chk("res_latency", lat, exp_lat);
    chk("res_data", o_res_data, exp_data);
    chk("res_timeout", o_res_timeout, exp_to);
    chk("start_count", starts, zero ? 0 : 1);
    chk("req_ready_resp", o_req_ready, 0);
    held = o_res_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", o_res_valid, 1);
      chk("hold_data", o_res_data, held);
      chk("hold_req_ready", o_req_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("res_valid_drop", o_res_valid, 0);
    chk("req_ready_back", o_req_ready, 1);
  endtask

  // Start an operation and assert reset between edges j_rst-1 and j_rst after acceptance.
  task automatic reset_at(input logic [7:0] a, input logic [7:0] b, input int j_rst);
    gcd_done = 1'b0; res_ready = 1'b1;
    req_valid = 1'b1; req_a = a; req_b = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int j = 1; j < j_rst; j++) @(negedge clk);
    if (j_rst == 1) chk("start_before_reset", o_gcd_start, 1);
    else chk("busy_before_reset", o_req_ready, 0);
    #2 reset = 1'b1;
    #1;
    chk("rst_req_ready", o_req_ready, 1);
    chk("rst_res_valid", o_res_valid, 0);
    chk("rst_res_data", o_res_data, 0);
    chk("rst_res_timeout", o_res_timeout, 0);
    chk("rst_gcd_start", o_gcd_start, 0);
    chk("rst_gcd_data_in", o_gcd_data_in, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    sel = 1'b0; reset = 1'b1; req_valid = 1'b0; req_a = 8'd0; req_b = 8'd0;
    res_ready = 1'b1; gcd_done = 1'b0; gcd_data_out = 8'd0;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", o_req_ready, 1);
    chk("reset_res_valid", o_res_valid, 0);
    chk("reset_res_data", o_res_data, 0);
    chk("reset_res_timeout", o_res_timeout, 0);
    chk("reset_gcd_start", o_gcd_start, 0);
    chk("reset_gcd_data_in", o_gcd_data_in, 0);
    reset = 1'b0;

    run_op(8'd48, 8'd18, 8, 0);
    run_op(8'd0, 8'd35, 0, 0);
    run_op(8'd0, 8'd0, 0, 0);
    run_op(8'd35, 8'd0, 0, 0);
    run_op(8'd100, 8'd75, 3, 20);

    sel = 1'b1;
    run_op(8'd84, 8'd36, 7, 0);
    run_op(8'd200, 8'd150, -1, 0);
    run_op(8'd9, 8'd6, 8, 1);

    sel = 1'b0;
    reset_at(8'd90, 8'd60, 5);
    run_op(8'd17, 8'd51, 2, 0);
    reset_at(8'd90, 8'd60, 1);
    run_op(8'd17, 8'd51, 0, 0);

    run_op(8'd12, 8'd8, int'($urandom_range(0, 5)), 0);
    run_op(8'd7, 8'd13, int'($urandom_range(0, 5)), 0);
    run_op(8'd255, 8'd85, int'($urandom_range(0, 5)), 0);

    repeat (30) begin
      ra = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      rb = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      run_op(ra, rb, int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
    end

    sel = 1'b1;
    repeat (12) begin
      ra = 8'($urandom_range(1, 255));
      rb = 8'($urandom_range(1, 255));
      rk = int'($urandom_range(0, 11));
      if (rk == 11) rk = -1;
      run_op(ra, rb, rk, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
